// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Receives an 8N1 UART byte stream (LSB first) and packs accepted bytes
//   big-endian into 32-bit words that are written to a word memory. Word 0
//   is a length header N (saturated to MAX_WORDS-1); after the header plus
//   N payload words the loader sets load_done and ignores further bytes.
//
// Ports
//   sysclk     : system clock, all logic on rising edge
//   rst        : synchronous active-high reset
//   RxSerial   : asynchronous UART line, idle high
//   mem_we     : one-cycle word write strobe
//   mem_addr   : byte address of the word write (word aligned)
//   mem_wdata  : assembled word
//   byte_valid : one-cycle pulse per accepted byte
//   load_done  : sticky, load complete
//   frame_err  : sticky, a stop bit was sampled low
module uart_word_loader #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        RxSerial,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        byte_valid,
  output logic        load_done,
  output logic        frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [31:0] MAX_LEN      = 32'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [31:0]   word_buf;
  logic [1:0]    byte_cnt;
  logic          word_ready;
  logic [29:0]   word_index;
  logic [29:0]   payload_len;
  logic          done_pending;

  logic [29:0]   header_len;
  logic          last_word;
  logic          busy;

  // The header word is still in word_buf when it is written, so its
  // saturated length is used directly to decide whether it is also the last.
  always_comb begin
    header_len = (word_buf > MAX_LEN) ? MAX_LEN[29:0] : word_buf[29:0];
    last_word  = (word_index == '0) ? (header_len == '0)
                                    : (word_index == payload_len);
    busy       = load_done | done_pending;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      word_buf     <= '0;
      byte_cnt     <= '0;
      word_ready   <= 1'b0;
      word_index   <= '0;
      payload_len  <= '0;
      done_pending <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      byte_valid   <= 1'b0;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_meta    <= RxSerial;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      mem_we     <= 1'b0;
      word_ready <= 1'b0;

      if (done_pending) begin
        load_done    <= 1'b1;
        done_pending <= 1'b0;
      end

      // Word write lands the cycle after the 4th byte_valid.
      if (word_ready) begin
        mem_we       <= 1'b1;
        mem_addr     <= {word_index, 2'b00};
        mem_wdata    <= word_buf;
        word_index   <= word_index + 30'd1;
        done_pending <= last_word;
        if (word_index == '0) payload_len <= header_len;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!busy) begin
              if (rx_sync) begin
                byte_valid <= 1'b1;
                word_buf   <= {word_buf[23:0], shift};
                byte_cnt   <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) word_ready <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter MAX_WORDS, default 256, capacity of the destination memory in 32-bit words.
REQ-004 SHALL have port sysclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port RxSerial, input, 1 bit: asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 SHALL have port mem_we, output, 1 bit: one-cycle word write strobe.
REQ-008 SHALL have port mem_addr, output, 32 bits: byte address of the word write, word aligned.
REQ-009 SHALL have port mem_wdata, output, 32 bits: assembled word.
REQ-010 SHALL have port byte_valid, output, 1 bit: one-cycle pulse for each accepted byte.
REQ-011 SHALL have port load_done, output, 1 bit: sticky flag, set when the load is complete.
REQ-012 SHALL have port frame_err, output, 1 bit: sticky flag, set when a stop bit is bad.

Function
REQ-013 SHALL pass RxSerial through a two-flop synchronizer before any use; the line is never sampled directly.
REQ-014 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncated (10416 at the defaults), with HALF = CLKS_PER_BIT/2.
REQ-015 SHALL implement the receiver FSM states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START SHALL occur on a synchronized falling edge (high then low). The baud counter is cleared on entry.
REQ-017 START SHALL wait HALF cycles and then resample the line:
- low: go to DATA with the counter cleared;
- high: treat it as a glitch and return to IDLE with no output.
REQ-018 DATA SHALL sample at every CLKS_PER_BIT interval and shift the bit into bit position 0..7, LSB first. After the 8th sample it goes to STOP.
REQ-019 STOP SHALL sample once after CLKS_PER_BIT cycles:
- high: the byte is accepted and byte_valid pulses for one cycle;
- low: frame_err is set, the byte is discarded, and the partial word keeps its current contents.
The FSM then returns to IDLE.
REQ-020 Accepted bytes SHALL be assembled big-endian. The first byte of a word is bits 31:24 and the fourth byte is bits 7:0.
REQ-021 On the 4th byte, mem_we SHALL pulse for exactly one cycle, in the cycle after the byte_valid of that byte. mem_wdata holds the word during that cycle, and mem_addr = word_index*4.
REQ-022 word_index SHALL start at 0 and increment after each write.
REQ-023 Word 0 SHALL be the count header N.
- It is written to address 0x0 like any other word.
- It is latched as the payload length, saturated to MAX_WORDS-1.
REQ-024 After word_index reaches N+1 (header plus N payload words), load_done SHALL be set one cycle after the final mem_we.
REQ-025 While load_done=1, every received byte SHALL be ignored: no byte_valid, no mem_we, and no index change.
REQ-026 A frame error SHALL NOT stop reception; the next valid byte continues the current word.
REQ-027 mem_addr and mem_wdata SHALL hold their last values between strobes.

Reset
REQ-028 While rst=1 on a clock edge, the following SHALL be cleared on that edge, aborting any byte or word in progress:
- FSM to IDLE;
- counters, shift register and word_index to 0;
- mem_we, byte_valid, load_done and frame_err to 0;
- mem_addr and mem_wdata to 0.
REQ-029 Both synchronizer flops SHALL reset to 1, so that no false start bit is seen when reset is released.

Verification
REQ-030 Stream of 84 bytes for the words 0x00000014, 0x000041A8, 0x00003AF2, ..., 0x00004955 at 9600 baud with a 100 MHz clock -> SHALL give 21 mem_we pulses:
- addr 0x0 / data 0x00000014;
- addr 0x4 / data 0x000041A8;
- addr 0x50 / data 0x00004955;
- then load_done=1 and frame_err=0.
REQ-031 Low glitch on RxSerial of CLKS_PER_BIT/4 cycles in IDLE -> SHALL give no byte_valid, with the FSM back in IDLE.
REQ-032 Byte 0xA5 sent with the stop bit driven 0 -> SHALL give frame_err=1, no byte_valid, and the byte dropped. The following valid bytes 00 00 00 00 -> a write of 0x00000000 at 0x0 and then load_done=1.
REQ-033 Header 0x00000000 -> SHALL give exactly one write (addr 0x0) and then load_done. Four further bytes -> no mem_we.
REQ-034 rst pulsed in the middle of the 3rd byte of word 1 -> SHALL clear all outputs. A fresh stream then starts again at addr 0x0.
REQ-035 Header 0x00001000 with MAX_WORDS=256 -> SHALL give load_done after exactly 256 writes, the last at addr 0x3FC.
